cassette_transport: RTL and testbench
=====================================

# cassette_transport

Parametrised tape-playback engine that replaces the free-running position counter in the cassette overlay SoC. It has four transport modes: play, fast-forward, rewind and stop. It reads tape bytes from the 1-cycle-latency tape RAM (`cas_dpram` port B) and delivers them on a valid/ready byte stream. It also exports position, end-of-tape and status signals for the overlay.

## Interface
Parameters:
- `ADDR_W`, 24, width of tape position and length.
- `DIV_W`, 13, width of the rate divider.
- `SEEK_STEP`, 64, bytes moved per seek tick in FFWD/REW.

Ports:
- `clk_sys`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  one-cycle command strobe.
- `cmd`  in  2  command code: 0 STOP, 1 PLAY, 2 FFWD, 3 REW.
- `rate_div`  in  DIV_W  tick period minus 1; sampled when a command is accepted.
- `tape_end`  in  ADDR_W  tape length in bytes; 0 means no tape.
- `loop_en`  in  1  wrap to 0 at end in PLAY instead of stopping.
- `rd_en`  out  1  RAM read strobe.
- `rd_addr`  out  ADDR_W  RAM address.
- `rd_data`  in  8  RAM data, valid 1 cycle after `rd_en`.
- `out_valid`  out  1  byte available.
- `out_data`  out  8  tape byte.
- `out_ready`  in  1  consumer accepts the byte.
- `pos`  out  ADDR_W  current tape position.
- `state`  out  2  current mode, same encoding as `cmd`.
- `at_end`  out  1  sticky; tape reached its end.
- `late`  out  1  sticky; a tick found the previous byte unaccepted.

## Operation
- States: STOP, PLAY, FFWD, REW.
- Reset values: all outputs 0; state = STOP; divider = 0.
- A command is accepted in any state.
  - On acceptance: divider cleared, `rate_div` latched, `late` cleared.
  - Any pending read or output byte is flushed (`out_valid` drops). This is the only case where `out_valid` falls without `out_ready`.
- PLAY, FFWD or REW with `tape_end` = 0: command ignored, state stays STOP.
- Re-issuing the current mode restarts the divider only.
- Divider counts 0..rate_div and wraps. A tick is the cycle in which the divider is 0 while in a non-STOP state.
- PLAY, tick with output register empty and no read in flight:
  - Issue `rd_en` with `rd_addr` = `pos`.
  - Capture `rd_data` into `out_data` and assert `out_valid`.
- PLAY, tick while `out_valid` is high or a read is in flight: no read is issued; `late` is set.
- PLAY, byte accepted (`out_valid` && `out_ready`):
  - If `pos` = `tape_end`-1: with `loop_en`, `pos` becomes 0; otherwise `pos` holds, state becomes STOP and `at_end` is set.
  - Otherwise `pos` increments by 1.
- FFWD, each tick: `pos` = min(`pos`+SEEK_STEP, `tape_end`-1). On reaching `tape_end`-1: STOP, `at_end` set. `loop_en` is ignored.
- REW, each tick: `pos` = max(`pos`-SEEK_STEP, 0). On reaching 0: STOP. `at_end` is cleared on the first REW tick.
- No reads are issued in FFWD or REW.
- `at_end` is also cleared when PLAY or FFWD is accepted with `pos` < `tape_end`-1.
- Arithmetic is performed at ADDR_W+1 bits to detect overflow/underflow before saturation.
- If `tape_end` changes so that `pos` ≥ `tape_end`: on the next tick in any mode, `pos` is forced to 0 and state goes to STOP.
- Reset asserted mid-operation: immediate return to reset values; an in-flight read is discarded.

## Timing
- All outputs are registered.
- PLAY accepted at clock edge E0 → `rd_en` high after E1 → `out_valid` high after E3 (3-cycle latency).
- Subsequent fetches occur every `rate_div`+1 cycles, provided the output was consumed.
- Byte accepted at edge E → `pos` updated after E; `out_valid` low after E unless a new capture coincides with that edge.
- `rd_en` is high for exactly one cycle per fetch.
- Command and acceptance in the same cycle: the command wins and the byte is flushed; `pos` is not advanced.

## Structure
- Package `cassette_pkg`:
  - `cas_mode_t` enum (STOP/PLAY/FFWD/REW) shared by the `cmd` and `state` encodings.
  - Default constants: `CAS_DEFAULT_DIV` = 6666, `CAS_ADDR_W` = 24.
- One sub-module, `cas_rate_div`: DIV_W counter with clear input, latched period and `tick` output.
- The FSM, fetch pipeline and position arithmetic live in the top module.

## Test plan
- `tape_end`=10, `rate_div`=3, PLAY, `out_ready`=1 → bytes at addresses 0..9 emitted, `out_valid` first high 3 cycles after the command; then STOP, `at_end`=1, `pos`=9.
- Same setup with `loop_en`=1 → address sequence 8, 9, 0, 1; state remains PLAY; `at_end` stays 0.
- `out_ready` held 0 for 10 cycles with `rate_div`=3 → one byte is held stable, `late`=1, `pos` does not advance; releasing `out_ready` advances `pos` by exactly 1.
- `tape_end`=200, `pos`=150, FFWD, `SEEK_STEP`=64 → `pos`=199 on the first tick, STOP, `at_end`=1. Then REW → ticks give 135, 71, 7, 0, then STOP with `at_end`=0.
- PLAY with `tape_end`=0 → state stays STOP; `rd_en` never asserted.
- `reset_n` pulsed low while a read is in flight → all outputs 0 asynchronously; no `out_valid` follows the release of reset.

Source files
------------

// File: rtl/cassette_pkg.sv
// Shared types and defaults for the cassette tape-playback engine.
package cassette_pkg;

  typedef enum logic [1:0] {
    CAS_STOP = 2'd0,
    CAS_PLAY = 2'd1,
    CAS_FFWD = 2'd2,
    CAS_REW  = 2'd3
  } cas_mode_t;

  localparam int CAS_DEFAULT_DIV = 6666;
  localparam int CAS_ADDR_W      = 24;

endpackage

// File: rtl/cas_rate_div.sv
// Rate divider: counts 0..period and wraps; tick_o marks count 0.
module cas_rate_div #(
  parameter int DIV_W = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;

  always_comb begin
    per_d = per_q;
    cnt_d = (cnt_q == per_q) ? '0 : cnt_q + DIV_W'(1);
    if (clr_i) begin
      cnt_d = '0;
      per_d = period_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/cassette_transport.sv
// Tape transport FSM (STOP/PLAY/FFWD/REW), tape RAM fetch pipeline and
// position arithmetic feeding a valid/ready byte stream.
module cassette_transport
  import cassette_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DIV_W     = 13,
  parameter int SEEK_STEP = 64
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [ADDR_W-1:0] tape_end,
  input  logic              loop_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pos,
  output logic [1:0]        state,
  output logic              at_end,
  output logic              late
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] STEP_X = AW1'(SEEK_STEP);

  cas_mode_t         state_q, state_d, cmd_m;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              at_end_q, at_end_d;
  logic              late_q, late_d;
  // vld_pipe[0]: read strobe cycle, vld_pipe[1]: RAM data returning
  logic [1:0]        vld_pipe_q, vld_pipe_d;

  logic              div_clr, div_tick, tick, cmd_take, flush;
  logic [ADDR_W:0]   pos_ext, end_ext, end_m1, fwd_ext, rew_ext;

  cas_rate_div #(.DIV_W(DIV_W)) u_div (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .clr_i   (div_clr),
    .period_i(rate_div),
    .tick_o  (div_tick)
  );

  assign cmd_m   = cas_mode_t'(cmd);
  assign pos_ext = {1'b0, pos_q};
  assign end_ext = {1'b0, tape_end};
  assign end_m1  = end_ext - AW1'(1);
  assign fwd_ext = pos_ext + STEP_X;
  assign rew_ext = pos_ext - STEP_X;

  // Motion commands with no tape loaded are dropped entirely.
  assign cmd_take = cmd_valid && !((cmd_m != CAS_STOP) && (tape_end == '0));
  assign flush    = cmd_take && (cmd_m != state_q);
  assign div_clr  = cmd_take;
  assign tick     = div_tick && (state_q != CAS_STOP) && !cmd_take;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    at_end_d    = at_end_q;
    late_d      = late_q;
    vld_pipe_d  = {vld_pipe_q[0], 1'b0};

    if (flush) begin
      state_d     = cmd_m;
      late_d      = 1'b0;
      out_valid_d = 1'b0;
      vld_pipe_d  = '0;
      if ((cmd_m == CAS_PLAY || cmd_m == CAS_FFWD) && (pos_ext < end_m1))
        at_end_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        if (state_q == CAS_PLAY) begin
          if (pos_ext == end_m1) begin
            if (loop_en) begin
              pos_d = '0;
            end else begin
              state_d  = CAS_STOP;
              at_end_d = 1'b1;
            end
          end else begin
            pos_d = pos_q + ADDR_W'(1);
          end
        end
      end

      if (vld_pipe_q[1]) begin
        out_valid_d = 1'b1;
        out_data_d  = rd_data;
      end

      if (tick) begin
        // Tape shrank under the head: park at 0 regardless of mode.
        if (pos_ext >= end_ext) begin
          pos_d   = '0;
          state_d = CAS_STOP;
        end else begin
          unique case (state_q)
            CAS_PLAY: begin
              if (out_valid_q || (|vld_pipe_q)) begin
                late_d = 1'b1;
              end else begin
                vld_pipe_d[0] = 1'b1;
                rd_addr_d     = pos_q;
              end
            end
            CAS_FFWD: begin
              if (fwd_ext >= end_m1) begin
                pos_d    = end_m1[ADDR_W-1:0];
                state_d  = CAS_STOP;
                at_end_d = 1'b1;
              end else begin
                pos_d = fwd_ext[ADDR_W-1:0];
              end
            end
            CAS_REW: begin
              at_end_d = 1'b0;
              if (rew_ext[ADDR_W] || (rew_ext == '0)) begin
                pos_d   = '0;
                state_d = CAS_STOP;
              end else begin
                pos_d = rew_ext[ADDR_W-1:0];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CAS_STOP;
      pos_q       <= '0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      at_end_q    <= 1'b0;
      late_q      <= 1'b0;
      vld_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      at_end_q    <= at_end_d;
      late_q      <= late_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  assign rd_en     = vld_pipe_q[0];
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pos       = pos_q;
  assign state     = state_q;
  assign at_end    = at_end_q;
  assign late      = late_q;

endmodule

// File: tb/tb_cassette_transport.sv
// Scenario bench for cassette_transport with a 1-cycle tape RAM model.
module tb_cassette_transport;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [12:0] rate_div = '0;
  logic [23:0] tape_end = '0;
  logic        loop_en = 1'b0;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [7:0]  rd_data = '0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [23:0] pos;
  logic [1:0]  state;
  logic        at_end;
  logic        late;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] addr_q[$];

  always #5 clk_sys = ~clk_sys;

  cassette_transport dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd),
    .rate_div(rate_div), .tape_end(tape_end), .loop_en(loop_en),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .pos(pos), .state(state), .at_end(at_end), .late(late)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'd13;
    return t ^ 8'h5A;
  endfunction

  always @(posedge clk_sys) if (rd_en) rd_data <= mem_byte(rd_addr);

  task automatic do_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; out_ready = 1'b0; loop_en = 1'b0;
    exp_q.delete(); addr_q.delete();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys) reset_n = 1'b1;
  endtask

  // Returns one time unit after the edge that samples the command.
  task automatic send_cmd(input logic [1:0] c, input int d);
    @(posedge clk_sys); #1;
    cmd = c; rate_div = 13'(d); cmd_valid = 1'b1;
    @(posedge clk_sys); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_sys);
    vectors++;
    if ({rd_en, rd_addr, out_valid, out_data, pos, state, at_end, late} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got pos=%0d state=%0d ov=%b rd_en=%b late=%b at_end=%b, want all 0",
               pos, state, out_valid, rd_en, late, at_end);
    end
  endtask

  task automatic test_play_end();
    int k;
    logic [7:0] eb; logic [23:0] ea;
    do_reset();
    tape_end = 24'd10; out_ready = 1'b1;
    for (int a = 0; a < 10; a++) begin exp_q.push_back(mem_byte(24'(a))); addr_q.push_back(24'(a)); end
    send_cmd(2'd1, 3);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk_sys); k++;
      if (k == 2) begin
        vectors++;
        if (rd_en !== 1'b1 || rd_addr !== 24'd0) begin
          miscompares++;
          $display("FAIL play_first_read: got rd_en=%b addr=%0d, want 1/0", rd_en, rd_addr);
        end
      end
    end
    // k counts negedges from the command edge; out_valid lands after the 3rd edge later.
    vectors++;
    if (k !== 4) begin
      miscompares++;
      $display("FAIL play_latency: got %0d negedges, want 4", k);
    end
    for (int c = 0; c < 200; c++) begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        eb = exp_q.pop_front(); ea = addr_q.pop_front();
        vectors++;
        if (out_data !== eb || pos !== ea) begin
          miscompares++;
          $display("FAIL play_byte: got data=%h pos=%0d, want data=%h pos=%0d", out_data, pos, eb, ea);
        end
      end
      if (exp_q.size() == 0 && state == 2'd0) break;
      @(negedge clk_sys);
    end
    vectors++;
    if (exp_q.size() != 0 || state !== 2'd0 || at_end !== 1'b1 || pos !== 24'd9) begin
      miscompares++;
      $display("FAIL play_end: got left=%0d state=%0d at_end=%b pos=%0d, want 0/0/1/9",
               exp_q.size(), state, at_end, pos);
    end
  endtask

  task automatic test_loop();
    logic [7:0] eb; logic [23:0] ea;
    do_reset();
    tape_end = 24'd10; out_ready = 1'b1; loop_en = 1'b1;
    for (int a = 0; a < 13; a++) begin exp_q.push_back(mem_byte(24'(a % 10))); addr_q.push_back(24'(a % 10)); end
    send_cmd(2'd1, 3);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      @(negedge clk_sys);
      if (out_valid && out_ready) begin
        eb = exp_q.pop_front(); ea = addr_q.pop_front();
        vectors++;
        if (out_data !== eb || pos !== ea) begin
          miscompares++;
          $display("FAIL loop_byte: got data=%h pos=%0d, want data=%h pos=%0d", out_data, pos, eb, ea);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0 || state !== 2'd1 || at_end !== 1'b0) begin
      miscompares++;
      $display("FAIL loop_state: got left=%0d state=%0d at_end=%b, want 0/1/0", exp_q.size(), state, at_end);
    end
    send_cmd(2'd0, 0);
  endtask

  task automatic test_backpressure();
    int k;
    logic [7:0] eb;
    do_reset();
    tape_end = 24'd10;
    exp_q.push_back(mem_byte(24'd0)); exp_q.push_back(mem_byte(24'd1));
    send_cmd(2'd1, 3);
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk_sys); k++; end
    eb = exp_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== eb || pos !== 24'd0) begin
        miscompares++;
        $display("FAIL hold_byte: got ov=%b data=%h pos=%0d, want 1/%h/0", out_valid, out_data, pos, eb);
      end
      @(negedge clk_sys);
    end
    vectors++;
    if (late !== 1'b1) begin
      miscompares++;
      $display("FAIL late_flag: got %b, want 1", late);
    end
    out_ready = 1'b1;
    @(posedge clk_sys); #1 out_ready = 1'b0;
    @(negedge clk_sys);
    vectors++;
    if (pos !== 24'd1 || late !== 1'b1) begin
      miscompares++;
      $display("FAIL release_pos: got pos=%0d late=%b, want 1/1", pos, late);
    end
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk_sys); k++; end
    eb = exp_q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== eb || pos !== 24'd1) begin
      miscompares++;
      $display("FAIL next_byte: got ov=%b data=%h pos=%0d, want 1/%h/1", out_valid, out_data, pos, eb);
    end
    // Command and acceptance on the same edge: command wins, pos stays.
    out_ready = 1'b1; cmd = 2'd0; cmd_valid = 1'b1;
    @(posedge clk_sys); #1 cmd_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk_sys);
    vectors++;
    if (pos !== 24'd1 || out_valid !== 1'b0 || state !== 2'd0 || late !== 1'b0) begin
      miscompares++;
      $display("FAIL cmd_vs_accept: got pos=%0d ov=%b state=%0d late=%b, want 1/0/0/0", pos, out_valid, state, late);
    end
  endtask

  task automatic test_seek();
    int cnt;
    logic [7:0] eb; logic [23:0] ea, last;
    do_reset();
    tape_end = 24'd200; out_ready = 1'b1;
    for (int a = 0; a < 150; a++) exp_q.push_back(mem_byte(24'(a)));
    send_cmd(2'd1, 0);
    cnt = 0;
    for (int c = 0; c < 2000 && cnt < 150; c++) begin
      @(negedge clk_sys);
      if (out_valid && out_ready) begin
        eb = exp_q.pop_front();
        vectors++;
        if (out_data !== eb || pos !== 24'(cnt)) begin
          miscompares++;
          $display("FAIL seek_fill: got data=%h pos=%0d, want %h/%0d", out_data, pos, eb, cnt);
        end
        cnt++;
        if (cnt == 150) begin @(posedge clk_sys); #1 out_ready = 1'b0; end
      end
    end
    send_cmd(2'd0, 0);
    vectors++;
    if (pos !== 24'd150) begin
      miscompares++;
      $display("FAIL seek_start: got pos=%0d, want 150", pos);
    end
    addr_q.push_back(24'd199);
    send_cmd(2'd2, 3);
    last = 24'd150;
    for (int c = 0; c < 20 && addr_q.size() != 0; c++) begin
      @(negedge clk_sys);
      if (pos != last) begin
        ea = addr_q.pop_front();
        vectors++;
        if (pos !== ea || state !== 2'd0 || at_end !== 1'b1) begin
          miscompares++;
          $display("FAIL ffwd: got pos=%0d state=%0d at_end=%b, want %0d/0/1", pos, state, at_end, ea);
        end
        last = pos;
      end
    end
    vectors++;
    if (addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL ffwd_timeout: got %0d steps pending, want 0", addr_q.size());
      addr_q.delete();
    end
    addr_q.push_back(24'd135); addr_q.push_back(24'd71); addr_q.push_back(24'd7); addr_q.push_back(24'd0);
    send_cmd(2'd3, 3);
    for (int c = 0; c < 60 && addr_q.size() != 0; c++) begin
      @(negedge clk_sys);
      if (pos != last) begin
        ea = addr_q.pop_front();
        vectors++;
        if (pos !== ea || at_end !== 1'b0) begin
          miscompares++;
          $display("FAIL rew_step: got pos=%0d at_end=%b, want %0d/0", pos, at_end, ea);
        end
        last = pos;
      end
    end
    vectors++;
    if (addr_q.size() != 0 || state !== 2'd0 || pos !== 24'd0 || at_end !== 1'b0) begin
      miscompares++;
      $display("FAIL rew_end: got left=%0d state=%0d pos=%0d at_end=%b, want 0/0/0/0",
               addr_q.size(), state, pos, at_end);
    end
  endtask

  task automatic test_no_tape();
    int rd_seen, st_bad;
    do_reset();
    tape_end = '0; out_ready = 1'b1;
    send_cmd(2'd1, 2);
    rd_seen = 0; st_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_sys);
      if (rd_en) rd_seen++;
      if (state != 2'd0) st_bad++;
    end
    vectors++;
    if (rd_seen != 0 || st_bad != 0) begin
      miscompares++;
      $display("FAIL no_tape: got rd_en cycles=%0d non-stop cycles=%0d, want 0/0", rd_seen, st_bad);
    end
  endtask

  task automatic test_reset_inflight();
    int bad;
    do_reset();
    tape_end = 24'd10; out_ready = 1'b1;
    send_cmd(2'd1, 3);
    @(negedge clk_sys); @(negedge clk_sys);
    vectors++;
    if (rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL inflight_setup: got rd_en=%b, want 1", rd_en);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({rd_en, rd_addr, out_valid, out_data, pos, state, at_end, late} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got rd_en=%b ov=%b state=%0d pos=%0d, want all 0", rd_en, out_valid, state, pos);
    end
    @(posedge clk_sys);
    @(negedge clk_sys) reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_sys);
      if (out_valid || rd_en || state != 2'd0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: got %0d active cycles, want 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_play_end();
    test_loop();
    test_backpressure();
    test_seek();
    test_no_tape();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
